fios_result_collector: RTL and testbench

// - Sink at the far end of the FIOS PE chain: captures the 17-bit RES words emitted by the last PE.
// - Reassembles the Montgomery product T (< 2p), performs the final conditional subtraction T - p,
//   and streams the reduced result, LSW first, over a valid/ready interface to the host-side logic.
// - The PE chain cannot stall. The input side is therefore a no-backpressure capture port.

---
 rtl/fios_result_collector_if.sv | 26 ++
 rtl/fios_result_collector.sv | 142 ++++++++++++++
 tb/tb_fios_result_collector.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/fios_result_collector_if.sv
// Result-collector bus: capture port from the last FIOS PE plus the valid/ready output stream.
// Signal suffixes are relative to the collector (the collector modport).
interface fios_result_collector_if #(
  parameter int WORD_WIDTH = 17
);
  logic                  res_valid_i;
  logic [WORD_WIDTH-1:0] res_word_i;
  logic                  res_carry_i;
  logic [WORD_WIDTH-1:0] p_word_i;
  logic                  in_ready_o;
  logic                  out_valid_o;
  logic                  out_ready_i;
  logic [WORD_WIDTH-1:0] out_word_o;
  logic                  out_last_o;
  logic                  out_carry_o;

  modport collector (
    input  res_valid_i, res_word_i, res_carry_i, p_word_i, out_ready_i,
    output in_ready_o, out_valid_o, out_word_o, out_last_o, out_carry_o
  );

  modport host (
    output res_valid_i, res_word_i, res_carry_i, p_word_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_word_o, out_last_o, out_carry_o
  );
endinterface

// File: rtl/fios_result_collector.sv
// Captures the FIOS PE chain result words, optionally applies the final T - p subtraction
// (macro FIOS_RC_FINAL_SUB_EN) and streams the result LSW first over valid/ready.
module fios_result_collector #(
  parameter int WORD_WIDTH = 17,
  parameter int WORD_COUNT = 16
) (
  input  logic                       clock_i,
  input  logic                       reset_n_i,
  fios_result_collector_if.collector bus,
  output logic                       busy_o,
  output logic                       err_overflow_o
);
  localparam int IDX_W = (WORD_COUNT > 1) ? $clog2(WORD_COUNT) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_COUNT - 1);

`ifdef FIOS_RC_FINAL_SUB_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_COLLECT = 2'd1, S_DECIDE = 2'd2, S_DRAIN = 2'd3} state_e;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_COLLECT = 2'd1, S_DRAIN = 2'd3} state_e;
`endif

  state_e                state_q, state_d;
  logic [IDX_W-1:0]      in_idx_q, in_idx_d;
  logic [IDX_W-1:0]      out_idx_q, out_idx_d;
  logic                  carry_q, carry_d;
  logic                  err_q, err_d;
  logic [WORD_WIDTH-1:0] t_buf_q [WORD_COUNT];
  logic                  in_ready;
  logic                  store_en;
  logic                  drain;
  logic [WORD_WIDTH-1:0] out_word;

  assign in_ready = (state_q == S_IDLE) || (state_q == S_COLLECT);
  assign store_en = bus.res_valid_i & in_ready;
  assign drain    = (state_q == S_DRAIN);

`ifdef FIOS_RC_FINAL_SUB_EN
  logic                  borrow_q, borrow_d;
  logic                  borrow_in;
  logic                  sel_diff;
  logic [WORD_WIDTH:0]   diff;
  logic [WORD_WIDTH-1:0] d_buf_q [WORD_COUNT];

  // Word 0 starts a fresh borrow chain; the MSB of the widened difference is the borrow out.
  assign borrow_in = (state_q == S_IDLE) ? 1'b0 : borrow_q;
  assign diff      = {1'b0, bus.res_word_i} - {1'b0, bus.p_word_i} - (WORD_WIDTH + 1)'(borrow_in);
  // {carry,T} >= {0,p} unless the chain borrowed with no carry to absorb it.
  assign sel_diff  = ~(borrow_q & ~carry_q);
  assign out_word  = sel_diff ? d_buf_q[out_idx_q] : t_buf_q[out_idx_q];
  assign bus.out_carry_o = 1'b0;
`else
  logic unused_p;
  assign unused_p = ^bus.p_word_i;
  assign out_word = t_buf_q[out_idx_q];
  assign bus.out_carry_o = drain & carry_q;
`endif

  assign bus.in_ready_o  = in_ready;
  assign bus.out_valid_o = drain;
  assign bus.out_word_o  = drain ? out_word : '0;
  assign bus.out_last_o  = drain & (out_idx_q == LAST_IDX);
  assign busy_o          = (state_q != S_IDLE);
  assign err_overflow_o  = err_q;

  always_comb begin
    state_d   = state_q;
    in_idx_d  = in_idx_q;
    out_idx_d = out_idx_q;
    carry_d   = carry_q;
    err_d     = err_q | (bus.res_valid_i & ~in_ready);
`ifdef FIOS_RC_FINAL_SUB_EN
    borrow_d  = borrow_q;
`endif
    case (state_q)
      S_IDLE, S_COLLECT: begin
        if (bus.res_valid_i) begin
          state_d = S_COLLECT;
`ifdef FIOS_RC_FINAL_SUB_EN
          borrow_d = diff[WORD_WIDTH];
`endif
          if (in_idx_q == LAST_IDX) begin
            in_idx_d = '0;
            carry_d  = bus.res_carry_i;
`ifdef FIOS_RC_FINAL_SUB_EN
            state_d  = S_DECIDE;
`else
            state_d  = S_DRAIN;
`endif
          end else begin
            in_idx_d = in_idx_q + IDX_W'(1);
          end
        end
      end
`ifdef FIOS_RC_FINAL_SUB_EN
      S_DECIDE: state_d = S_DRAIN;
`endif
      S_DRAIN: begin
        if (bus.out_ready_i) begin
          if (out_idx_q == LAST_IDX) begin
            out_idx_d = '0;
            state_d   = S_IDLE;
          end else begin
            out_idx_d = out_idx_q + IDX_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q   <= S_IDLE;
      in_idx_q  <= '0;
      out_idx_q <= '0;
      carry_q   <= 1'b0;
      err_q     <= 1'b0;
`ifdef FIOS_RC_FINAL_SUB_EN
      borrow_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      in_idx_q  <= in_idx_d;
      out_idx_q <= out_idx_d;
      carry_q   <= carry_d;
      err_q     <= err_d;
`ifdef FIOS_RC_FINAL_SUB_EN
      borrow_q  <= borrow_d;
`endif
    end
  end

  // Word buffers hold data only and are never reset.
  always_ff @(posedge clock_i) begin
    if (store_en) begin
      t_buf_q[in_idx_q] <= bus.res_word_i;
`ifdef FIOS_RC_FINAL_SUB_EN
      d_buf_q[in_idx_q] <= diff[WORD_WIDTH-1:0];
`endif
    end
  end
endmodule

// File: tb/tb_fios_result_collector.sv
// Directed bench for fios_result_collector with WORD_COUNT = 2; expectations follow FIOS_RC_FINAL_SUB_EN.
module tb_fios_result_collector;
`ifdef FIOS_RC_FINAL_SUB_EN
  localparam bit SUB = 1'b1;
`else
  localparam bit SUB = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy, err;
  int   checks = 0;
  int   errors = 0;

  fios_result_collector_if #(.WORD_WIDTH(17)) bus ();

  fios_result_collector #(.WORD_WIDTH(17), .WORD_COUNT(2)) dut (
    .clock_i        (clk),
    .reset_n_i      (rst_n),
    .bus            (bus),
    .busy_o         (busy),
    .err_overflow_o (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Entered and left on a falling edge; the word is captured on the rising edge in between.
  task automatic send(input logic [16:0] r, input logic [16:0] p, input logic c);
    bus.res_valid_i = 1'b1;
    bus.res_word_i  = r;
    bus.p_word_i    = p;
    bus.res_carry_i = c;
    @(negedge clk);
    bus.res_valid_i = 1'b0;
    bus.res_carry_i = 1'b0;
  endtask

  task automatic wait_decide(input string nm);
    if (SUB) begin
      chk({nm, "_decide_valid"}, bus.out_valid_o, 1'b0);
      chk({nm, "_decide_busy"}, busy, 1'b1);
      @(negedge clk);
    end
  endtask

  task automatic run_txn(input string nm, input logic [16:0] p1, input logic [16:0] p0,
                         input logic [16:0] t1, input logic [16:0] t0, input logic c,
                         input logic [16:0] e1, input logic [16:0] e0, input logic ec);
    send(t0, p0, 1'b0);
    send(t1, p1, c);
    wait_decide(nm);
    chk({nm, "_valid0"}, bus.out_valid_o, 1'b1);
    chk({nm, "_word0"}, bus.out_word_o, e0);
    chk({nm, "_last0"}, bus.out_last_o, 1'b0);
    chk({nm, "_carry0"}, bus.out_carry_o, ec);
    bus.out_ready_i = 1'b1;
    @(negedge clk);
    chk({nm, "_word1"}, bus.out_word_o, e1);
    chk({nm, "_last1"}, bus.out_last_o, 1'b1);
    chk({nm, "_carry1"}, bus.out_carry_o, ec);
    @(negedge clk);
    bus.out_ready_i = 1'b0;
    chk({nm, "_idle_busy"}, busy, 1'b0);
    chk({nm, "_idle_valid"}, bus.out_valid_o, 1'b0);
    chk({nm, "_idle_inrdy"}, bus.in_ready_o, 1'b1);
  endtask

  initial begin
    bus.res_valid_i = 1'b0;
    bus.res_word_i  = '0;
    bus.res_carry_i = 1'b0;
    bus.p_word_i    = '0;
    bus.out_ready_i = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_inrdy", bus.in_ready_o, 1'b1);
    chk("rst_valid", bus.out_valid_o, 1'b0);
    chk("rst_word", bus.out_word_o, 17'h0);
    chk("rst_last", bus.out_last_o, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_err", err, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    run_txn("reduce", 17'h00001, 17'h00005, 17'h00001, 17'h00007, 1'b0,
            SUB ? 17'h00000 : 17'h00001, SUB ? 17'h00002 : 17'h00007, 1'b0);
    run_txn("noreduce", 17'h00001, 17'h00005, 17'h00001, 17'h00003, 1'b0,
            17'h00001, 17'h00003, 1'b0);
    run_txn("xborrow", 17'h00001, 17'h00001, 17'h00002, 17'h00000, 1'b0,
            SUB ? 17'h00000 : 17'h00002, SUB ? 17'h1FFFF : 17'h00000, 1'b0);
    run_txn("carry", 17'h1FFFF, 17'h1FFFF, 17'h00000, 17'h00004, 1'b1,
            17'h00000, SUB ? 17'h00005 : 17'h00004, SUB ? 1'b0 : 1'b1);

    // Backpressure with words injected while draining.
    send(17'h00007, 17'h00005, 1'b0);
    send(17'h00001, 17'h00001, 1'b0);
    wait_decide("bp");
    chk("bp_err_before", err, 1'b0);
    for (int i = 0; i < 5; i++) begin
      bus.res_valid_i = 1'b1;
      bus.res_word_i  = 17'h0ABCD;
      chk("bp_inrdy", bus.in_ready_o, 1'b0);
      @(negedge clk);
      chk("bp_valid_hold", bus.out_valid_o, 1'b1);
      chk("bp_word_hold", bus.out_word_o, SUB ? 17'h00002 : 17'h00007);
      chk("bp_last_hold", bus.out_last_o, 1'b0);
      chk("bp_err", err, 1'b1);
    end
    bus.res_valid_i = 1'b0;
    bus.out_ready_i = 1'b1;
    @(negedge clk);
    chk("bp_word1", bus.out_word_o, SUB ? 17'h00000 : 17'h00001);
    chk("bp_last1", bus.out_last_o, 1'b1);
    @(negedge clk);
    bus.out_ready_i = 1'b0;
    chk("bp_idle_busy", busy, 1'b0);
    chk("bp_err_sticky", err, 1'b1);

    // Asynchronous reset after word 0 of a capture.
    send(17'h00003, 17'h00001, 1'b0);
    chk("ar_busy_before", busy, 1'b1);
    chk("ar_inrdy_before", bus.in_ready_o, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_busy", busy, 1'b0);
    chk("ar_inrdy", bus.in_ready_o, 1'b1);
    chk("ar_valid", bus.out_valid_o, 1'b0);
    chk("ar_word", bus.out_word_o, 17'h0);
    chk("ar_err", err, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_txn("after_rst", 17'h00001, 17'h00001, 17'h00002, 17'h00000, 1'b0,
            SUB ? 17'h00000 : 17'h00002, SUB ? 17'h1FFFF : 17'h00000, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
